// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - burst-granting arbiter for the VGA adapter pixel-write port
module vga_plot_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int MAX_BURST = 0,
    parameter int BURST_W   = 17
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [9*NUM_REQ-1:0]   x_in,
    input  logic [8*NUM_REQ-1:0]   y_in,
    input  logic [3*NUM_REQ-1:0]   colour_in,
    output logic [NUM_REQ-1:0]     ack,
    output logic [8:0]             x,
    output logic [7:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic [2:0]             owner,
    output logic                   busy
);

    // A limit that does not fit the counter can never be reached, so it acts as unlimited.
    localparam logic LIMIT_EN = (MAX_BURST > 0) &&
                                (longint'(MAX_BURST) < (longint'(1) << BURST_W));
    localparam logic [BURST_W-1:0] LIMIT = BURST_W'(MAX_BURST);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state, state_next;
    logic [2:0]           owner_next;
    logic [BURST_W-1:0]   cnt, cnt_next, cnt_inc;
    logic                 demote, demote_next;
    logic [2:0]           demote_idx, demote_idx_next;

    logic                 owner_req;
    logic [NUM_REQ-1:0]   owner_oh, demote_oh, cand;
    logic [8:0]           own_x;
    logic [7:0]           own_y;
    logic [2:0]           own_c, sel;

    always_comb begin
        owner_req = 1'b0;
        owner_oh  = '0;
        demote_oh = '0;
        own_x     = '0;
        own_y     = '0;
        own_c     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 3'(i)) begin
                owner_req   = req[i];
                owner_oh[i] = 1'b1;
                own_x       = x_in[9*i +: 9];
                own_y       = y_in[8*i +: 8];
                own_c       = colour_in[3*i +: 3];
            end
            if (demote_idx == 3'(i))
                demote_oh[i] = 1'b1;
        end
    end

    // Lowest index wins; a demoted owner steps aside only when someone else is waiting.
    always_comb begin
        cand = req;
        if (demote && ((req & ~demote_oh) != '0))
            cand = req & ~demote_oh;
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (cand[i])
                sel = 3'(i);
    end

    assign cnt_inc = cnt + BURST_W'(1);
    assign busy    = (state == OWN);

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        cnt_next        = cnt;
        demote_next     = demote;
        demote_idx_next = demote_idx;
        ack             = '0;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    owner_next  = sel;
                    demote_next = 1'b0;
                    state_next  = OWN;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    ack = reset ? '0 : owner_oh;
                    if (LIMIT_EN && (cnt_inc == LIMIT)) begin
                        state_next      = IDLE;
                        cnt_next        = '0;
                        demote_next     = 1'b1;
                        demote_idx_next = owner;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            cnt        <= '0;
            demote     <= 1'b0;
            demote_idx <= '0;
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            cnt        <= cnt_next;
            demote     <= demote_next;
            demote_idx <= demote_idx_next;
            plot       <= (ack != '0);
            if (ack != '0) begin
                x      <= own_x;
                y      <= own_y;
                colour <= own_c;
            end
        end
    end

endmodule
